// File: rtl/fpu_ss_pkg.sv
// Shared definitions for the FP subsystem writeback path: the default
// starvation bound, the writeback request record and a one-hot helper.
package fpu_ss_pkg;

  // Default maximum number of consecutive cycles a waiting LSU result
  // may lose arbitration before it is forced through.
  localparam int unsigned MaxStallDefault = 4;

  // Number of architectural FP registers and hazard-check operand ports.
  localparam int unsigned NumRegs = 32;
  localparam int unsigned NumChk  = 3;

  // One register-file write: destination and data.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wdata;
  } wb_req_t;

  // One-hot register mask, all zero when the enable is low.
  function automatic logic [NumRegs-1:0] reg_mask(input logic en, input logic [4:0] idx);
    logic [NumRegs-1:0] mask;
    mask = '0;
    if (en) mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/fpu_ss_scoreboard.sv
// Pending-write scoreboard for the FP register file. One bit per register:
// set when an instruction with that destination issues, cleared when the
// write to that register commits. Also answers operand hazard queries.
module fpu_ss_scoreboard
  import fpu_ss_pkg::*;
#(
  parameter int unsigned NumChkPorts = NumChk
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         set_en_i,
  input  logic [4:0]                   set_addr_i,
  input  logic                         clr_en_i,
  input  logic [4:0]                   clr_addr_i,
  input  logic [NumChkPorts-1:0][4:0]  chk_addr_i,
  output logic [NumChkPorts-1:0]       chk_busy_o,
  output logic [NumRegs-1:0]           pending_o
);

  logic [NumRegs-1:0] pending_q;
  logic [NumRegs-1:0] pending_d;

  // Next scoreboard value: clear first, then set, so a clear and a set of
  // different registers in the same cycle both land, and a new issue to a
  // register that is simultaneously being written stays pending.
  always_comb begin
    pending_d = (pending_q & ~reg_mask(clr_en_i, clr_addr_i)) | reg_mask(set_en_i, set_addr_i);
  end

  // Scoreboard register with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Per-operand hazard lookup straight from the registered state.
  always_comb begin
    chk_busy_o = '0;
    for (int i = 0; i < int'(NumChkPorts); i++) begin
      chk_busy_o[i] = pending_q[chk_addr_i[i]];
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/fpu_ss_wb_arbiter.sv
// FP register-file writeback arbiter. Two result producers (FPU and LSU)
// compete for a single write port; the FPU wins by default and the LSU is
// forced through after MaxStall consecutive lost cycles. The winner is
// registered and written one cycle later. A scoreboard tracks registers
// with writes outstanding, stalling WAW issues and flagging operand hazards.
//
// Handshake: every channel transfers in a cycle where valid and ready are
// both high. A requester holds valid and its payload stable until accepted.
// fpu_ready_o/lsu_ready_o depend only on the valids and the stall counter,
// never on the payload; issue_ready_o depends on the scoreboard bit of the
// issuing destination (WAW check). At most one result ready is high.
module fpu_ss_wb_arbiter
  import fpu_ss_pkg::*;
#(
  parameter int unsigned MaxStall = MaxStallDefault
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   issue_valid_i,
  input  logic [4:0]             issue_rd_i,
  output logic                   issue_ready_o,
  input  logic                   fpu_valid_i,
  input  logic [4:0]             fpu_rd_i,
  input  logic [31:0]            fpu_wdata_i,
  output logic                   fpu_ready_o,
  input  logic                   lsu_valid_i,
  input  logic [4:0]             lsu_rd_i,
  input  logic [31:0]            lsu_wdata_i,
  output logic                   lsu_ready_o,
  output logic                   rf_we_o,
  output logic [4:0]             rf_waddr_o,
  output logic [31:0]            rf_wdata_o,
  input  logic [NumChk-1:0][4:0] chk_raddr_i,
  output logic [NumChk-1:0]      chk_busy_o,
  output logic [NumRegs-1:0]     pending_o
);

  // Counter wide enough to hold MaxStall (at least one bit).
  localparam int unsigned CntW = (MaxStall > 0) ? $clog2(MaxStall + 1) : 1;
  localparam logic [CntW-1:0] StallLimit = CntW'(MaxStall);

  logic [CntW-1:0] stall_q;
  logic [CntW-1:0] stall_d;
  logic            lsu_grant;
  logic            fpu_grant;
  logic            issue_hs;
  wb_req_t         sel_req;
  wb_req_t         wb_q;
  logic            rf_we_q;

  // Arbitration: LSU wins when it is alone or has been starved long enough.
  always_comb begin
    lsu_grant = lsu_valid_i && (!fpu_valid_i || (stall_q == StallLimit));
    fpu_grant = fpu_valid_i && !lsu_grant;
  end

  assign fpu_ready_o = fpu_grant;
  assign lsu_ready_o = lsu_grant;

  // Starvation counter: counts consecutive lost cycles of a waiting LSU
  // result, saturating at the limit; idle or granted clears it.
  always_comb begin
    stall_d = stall_q;
    if (!lsu_valid_i || lsu_grant) begin
      stall_d = '0;
    end else if (stall_q != StallLimit) begin
      stall_d = stall_q + CntW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  // Payload of whichever producer holds the grant this cycle.
  always_comb begin
    sel_req = '0;
    if (lsu_grant) begin
      sel_req.rd    = lsu_rd_i;
      sel_req.wdata = lsu_wdata_i;
    end else begin
      sel_req.rd    = fpu_rd_i;
      sel_req.wdata = fpu_wdata_i;
    end
  end

  // Writeback register: one write per cycle, one cycle after the handshake.
  // Reset drops any write in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q <= 1'b0;
      wb_q    <= '0;
    end else begin
      rf_we_q <= fpu_grant || lsu_grant;
      if (fpu_grant || lsu_grant) begin
        wb_q <= sel_req;
      end
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = wb_q.rd;
  assign rf_wdata_o = wb_q.wdata;

  // Issue is refused while a write to the same destination is outstanding.
  assign issue_ready_o = ~pending_o[issue_rd_i];
  assign issue_hs      = issue_valid_i && issue_ready_o;

  fpu_ss_scoreboard #(
    .NumChkPorts (NumChk)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set_en_i   (issue_hs),
    .set_addr_i (issue_rd_i),
    .clr_en_i   (rf_we_q),
    .clr_addr_i (wb_q.rd),
    .chk_addr_i (chk_raddr_i),
    .chk_busy_o (chk_busy_o),
    .pending_o  (pending_o)
  );

endmodule

// File: doc/fpu_ss_wb_arbiter.md
FPU_SS_WB_ARBITER -- requirements
Module: fpu_ss_wb_arbiter

Interface
REQ-001 SHALL have parameter MaxStall, default 4: maximum consecutive cycles a valid LSU request may lose arbitration.
REQ-002 SHALL have port clk_i, input, 1: clock, rising-edge.
REQ-003 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port issue_valid_i, input, 1: instruction with FP destination issuing.
REQ-005 SHALL have port issue_rd_i, input, 5: destination register of the issuing instruction.
REQ-006 SHALL have port issue_ready_o, output, 1: issue accepted; combinational.
REQ-007 SHALL have port fpu_valid_i, input, 1: FPU result valid.
REQ-008 SHALL have port fpu_rd_i, input, 5: destination of the FPU result.
REQ-009 SHALL have port fpu_wdata_i, input, 32: FPU result data.
REQ-010 SHALL have port fpu_ready_o, output, 1: FPU result accepted.
REQ-011 SHALL have port lsu_valid_i, input, 1: load result valid.
REQ-012 SHALL have port lsu_rd_i, input, 5: destination of the load result.
REQ-013 SHALL have port lsu_wdata_i, input, 32: load result data.
REQ-014 SHALL have port lsu_ready_o, output, 1: load result accepted.
REQ-015 SHALL have port rf_we_o, output, 1: register-file write enable; registered.
REQ-016 SHALL have port rf_waddr_o, output, 5: register-file write address; registered.
REQ-017 SHALL have port rf_wdata_o, output, 32: register-file write data; registered.
REQ-018 SHALL have port chk_raddr_i, input, 3x5: operand addresses to hazard-check.
REQ-019 SHALL have port chk_busy_o, output, 3: per operand, the register has a pending write; combinational.
REQ-020 SHALL have port pending_o, output, 32: scoreboard bit vector.

Function
REQ-021 Handshake: a transfer SHALL occur when valid and ready are both high in the same cycle.
REQ-022 Valid/ready: ready SHALL NOT depend on the requester's own data; a requester SHALL hold valid and data stable until accepted.
REQ-023 Grant: at most one of fpu_ready_o and lsu_ready_o SHALL be high per cycle.
REQ-024 Grant: each ready SHALL be high only when its valid is high.
REQ-025 Priority: FPU SHALL win by default.
REQ-026 Starvation: LSU SHALL win when stall_cnt equals MaxStall.
REQ-027 stall_cnt SHALL increment, saturating at MaxStall, each cycle lsu_valid_i is high and not granted.
REQ-028 stall_cnt SHALL clear on an LSU grant, or when lsu_valid_i is low.
REQ-029 Writeback: the accepted request SHALL appear on rf_we_o/rf_waddr_o/rf_wdata_o the cycle after the handshake (1-cycle latency).
REQ-030 Writeback: rf_we_o SHALL be low in cycles with no preceding handshake.
REQ-031 Writeback: full throughput of one write per cycle SHALL be supported.
REQ-032 Scoreboard set: bit issue_rd_i SHALL be set on an issue handshake.
REQ-033 issue_ready_o SHALL be low while pending_o[issue_rd_i] is 1 (WAW stall).
REQ-034 Scoreboard clear: bit rf_waddr_o SHALL be cleared at the clock edge ending a cycle with rf_we_o high.
REQ-035 A set and a clear of different bits in the same cycle SHALL both take effect.
REQ-036 chk_busy_o[i] SHALL equal pending_o[chk_raddr_i[i]].
REQ-037 chk_busy_o SHALL read 0 in the cycle after the write commits.
REQ-038 A writeback to a non-pending rd SHALL still be written, with the scoreboard unchanged.
REQ-039 Register 0 SHALL be treated like any other register (FP f0 is writable).

Reset
REQ-040 On rst_ni low, asynchronously: pending_o = 0.
REQ-041 On rst_ni low, asynchronously: stall_cnt = 0.
REQ-042 On rst_ni low, asynchronously: rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0.
REQ-043 During reset, issue_ready_o SHALL follow its combinational rule on the cleared state (1).
REQ-044 During reset, grants SHALL follow their combinational rules.
REQ-045 A handshake in the reset cycle SHALL be discarded.
REQ-046 Reset mid-operation SHALL drop any in-flight writeback.

Structure
REQ-047 fpu_ss_pkg SHALL hold the MaxStall default and typedef wb_req_t {rd[4:0], wdata[31:0]}.
REQ-048 The scoreboard SHALL be the sub-module fpu_ss_scoreboard, with set port, clear port, 3 check ports and the pending vector.
REQ-049 The arbitration and writeback register SHALL reside in the top module.

Verification
REQ-050 Issue rd=5; FPU writes rd=5, data 0x3F800000 -> fpu_ready_o=1; next cycle rf_we_o=1, waddr=5, wdata=0x3F800000; the cycle after, pending_o[5]=0.
REQ-051 FPU and LSU valid continuously, MaxStall=4 -> LSU granted every 5th cycle; one rf write per cycle; no cycle has both readies high.
REQ-052 rd=7 pending; issue rd=7 -> issue_ready_o=0 until the cycle after rf_we_o with waddr=7, then 1.
REQ-053 Issue rd=3 while writeback rd=9 commits -> pending_o[3]=1 and pending_o[9]=0 after the edge.
REQ-054 rd=2 pending; chk_raddr_i={2,4,2} -> chk_busy_o=3'b101.
REQ-055 Assert rst_ni low in the cycle after an LSU handshake -> rf_we_o=0 immediately, pending_o=0, stall_cnt=0.
